// File: rtl/alu_pipe.sv
// Handshaked RV integer ALU: base ops and edge-case divides finish in one registered cycle,
// while MUL/MULHU/DIV/DIVU/REM/REMU iterate XLEN cycles through a shared accumulator.
module alu_pipe #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            illegal,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLL   = 5'd2;
    localparam logic [4:0] OP_SLT   = 5'd3;
    localparam logic [4:0] OP_SLTU  = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_OR    = 5'd8;
    localparam logic [4:0] OP_AND   = 5'd9;
    localparam logic [4:0] OP_MUL   = 5'd10;
    localparam logic [4:0] OP_MULHU = 5'd11;
    localparam logic [4:0] OP_DIVU  = 5'd12;
    localparam logic [4:0] OP_REMU  = 5'd13;
    localparam logic [4:0] OP_DIV   = 5'd14;
    localparam logic [4:0] OP_REM   = 5'd15;

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [63:0]         iter;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     opnd;
    logic [4:0]          op_q;
    logic                neg_q;
    logic                neg_r;

    logic                accept;
    logic [SHW-1:0]      shamt;
    logic                div_zero;
    logic                div_ovf;
    logic                signed_div;
    logic                rs1_neg;
    logic                rs2_neg;
    logic [XLEN-1:0]     mag1;
    logic [XLEN-1:0]     mag2;
    logic                is_iter;
    logic                is_mul;
    logic [XLEN-1:0]     fast_rd;
    logic                fast_ill;

    logic                mul_q;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;
    logic [2*XLEN-1:0]   mul_next;
    logic [2*XLEN-1:0]   div_next;
    logic [XLEN-1:0]     fin_rd;

    assign accept     = in_valid && in_ready;
    assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
    assign busy       = (state != IDLE);

    assign shamt      = rs2[SHW-1:0];
    assign div_zero   = (rs2 == '0);
    assign div_ovf    = (rs1 == SMIN) && (rs2 == '1);
    assign signed_div = (op == OP_DIV) || (op == OP_REM);
    assign rs1_neg    = signed_div && rs1[XLEN-1];
    assign rs2_neg    = signed_div && rs2[XLEN-1];
    assign mag1       = rs1_neg ? -rs1 : rs1;
    assign mag2       = rs2_neg ? -rs2 : rs2;
    assign is_mul     = (op == OP_MUL) || (op == OP_MULHU);

    always_comb begin
        fast_rd  = '0;
        fast_ill = 1'b0;
        is_iter  = 1'b0;
        case (op)
            OP_ADD:   fast_rd = rs1 + rs2;
            OP_SUB:   fast_rd = rs1 - rs2;
            OP_SLL:   fast_rd = rs1 << shamt;
            OP_SLT:   fast_rd = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
            OP_SLTU:  fast_rd = {{(XLEN-1){1'b0}}, rs1 < rs2};
            OP_XOR:   fast_rd = rs1 ^ rs2;
            OP_SRL:   fast_rd = rs1 >> shamt;
            OP_SRA:   fast_rd = $signed(rs1) >>> shamt;
            OP_OR:    fast_rd = rs1 | rs2;
            OP_AND:   fast_rd = rs1 & rs2;
            OP_MUL, OP_MULHU: is_iter = 1'b1;
            // Divide-by-zero and signed overflow have fixed answers, so they skip the iteration.
            OP_DIVU:  if (div_zero) fast_rd = '1; else is_iter = 1'b1;
            OP_REMU:  if (div_zero) fast_rd = rs1; else is_iter = 1'b1;
            OP_DIV: begin
                if (div_zero)     fast_rd = '1;
                else if (div_ovf) fast_rd = rs1;
                else              is_iter = 1'b1;
            end
            OP_REM: begin
                if (div_zero)     fast_rd = rs1;
                else if (div_ovf) fast_rd = '0;
                else              is_iter = 1'b1;
            end
            default:  fast_ill = 1'b1;
        endcase
    end

    // acc holds {high product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    assign mul_q     = (op_q == OP_MUL) || (op_q == OP_MULHU);
    assign mul_sum   = acc[0] ? ({1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd})
                              : {1'b0, acc[2*XLEN-1:XLEN]};
    assign mul_next  = {mul_sum, acc[XLEN-1:1]};
    assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    always_comb begin
        fin_rd = '0;
        case (op_q)
            OP_MUL:   fin_rd = acc[XLEN-1:0];
            OP_MULHU: fin_rd = acc[2*XLEN-1:XLEN];
            OP_DIVU:  fin_rd = acc[XLEN-1:0];
            OP_REMU:  fin_rd = acc[2*XLEN-1:XLEN];
            OP_DIV:   fin_rd = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            OP_REM:   fin_rd = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
            default:  fin_rd = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            rd        <= '0;
            illegal   <= 1'b0;
            iter      <= '0;
            acc       <= '0;
            opnd      <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_iter) begin
                            state <= CALC;
                            iter  <= '0;
                            op_q  <= op;
                            neg_q <= rs1_neg ^ rs2_neg;
                            neg_r <= rs1_neg;
                            if (is_mul) begin
                                acc  <= {{XLEN{1'b0}}, rs2};
                                opnd <= rs1;
                            end else begin
                                acc  <= {{XLEN{1'b0}}, mag1};
                                opnd <= mag2;
                            end
                        end else begin
                            rd        <= fast_rd;
                            illegal   <= fast_ill;
                            out_valid <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    acc  <= mul_q ? mul_next : div_next;
                    iter <= iter + 64'd1;
                    if (iter == 64'(XLEN - 1))
                        state <= DONE;
                end
                DONE: begin
                    rd        <= fin_rd;
                    illegal   <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
